// File: rtl/ps2_pkg.sv
// ============================================================================
// Module      : ps2_pkg
// Description : Shared scan-code constants and frame FSM encoding for the
//               PS/2 Space-key receiver.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_SPACE = 8'h29;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

endpackage

`default_nettype wire

// File: rtl/ps2_frame_rx.sv
// ============================================================================
// Module      : ps2_frame_rx
// Description : PS/2 line conditioning and 11-bit frame receiver with
//               parity/stop checking and inter-edge timeout.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_error
);

    localparam int c_FILT_W = $clog2(FILTER_LEN + 1);
    localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_FILT_W-1:0] c_FILT_MAX = c_FILT_W'(FILTER_LEN - 1);
    localparam logic [c_TO_W-1:0]   c_TO_MAX   = c_TO_W'(TIMEOUT_CYCLES - 1);

    logic                r_clk_meta, r_clk_sync;
    logic                r_data_meta, r_data_sync;
    logic [c_FILT_W-1:0] r_filt_cnt;
    logic                r_filt_clk, r_filt_prev;
    logic                w_fall;

    frame_state_t        r_state, w_state_next;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic                r_parity;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic                w_shift_en, w_par_en, w_valid, w_error, w_timeout;

    logic [7:0]          r_scan_code;
    logic                r_scan_valid, r_frame_error;

    // Idle PS/2 lines are high, so the synchronisers reset to 1 to avoid a
    // spurious falling edge when reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_meta  <= 1'b1;
            r_clk_sync  <= 1'b1;
            r_data_meta <= 1'b1;
            r_data_sync <= 1'b1;
            r_filt_cnt  <= '0;
            r_filt_clk  <= 1'b1;
            r_filt_prev <= 1'b1;
        end else begin
            r_clk_meta  <= ps2_clk;
            r_clk_sync  <= r_clk_meta;
            r_data_meta <= ps2_data;
            r_data_sync <= r_data_meta;
            r_filt_prev <= r_filt_clk;
            if (r_clk_sync == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == c_FILT_MAX) begin
                r_filt_clk <= r_clk_sync;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_fall = r_filt_prev & ~r_filt_clk;

    always_comb begin
        w_state_next = r_state;
        w_shift_en   = 1'b0;
        w_par_en     = 1'b0;
        w_valid      = 1'b0;
        w_error      = 1'b0;
        w_timeout    = (r_state != ST_IDLE) && (r_to_cnt == c_TO_MAX);
        if (w_fall) begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_data_sync) w_state_next = ST_DATA;
                    else              w_error      = 1'b1;
                end
                ST_DATA: begin
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 3'd7) w_state_next = ST_PARITY;
                end
                ST_PARITY: begin
                    w_par_en     = 1'b1;
                    w_state_next = ST_STOP;
                end
                ST_STOP: begin
                    w_state_next = ST_IDLE;
                    // Odd parity over data plus parity bit, stop bit high.
                    if (r_data_sync && (^{r_shift, r_parity})) w_valid = 1'b1;
                    else                                       w_error = 1'b1;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_next = ST_IDLE;
            w_error      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_bit_cnt     <= 3'd0;
            r_shift       <= 8'd0;
            r_parity      <= 1'b0;
            r_to_cnt      <= '0;
            r_scan_code   <= 8'd0;
            r_scan_valid  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_fall && (r_state == ST_IDLE)) begin
                r_bit_cnt <= 3'd0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= {r_data_sync, r_shift[7:1]};
            end
            if (w_par_en) r_parity <= r_data_sync;
            if (w_fall || w_timeout || (r_state == ST_IDLE)) r_to_cnt <= '0;
            else                                             r_to_cnt <= r_to_cnt + 1'b1;
            r_scan_valid  <= w_valid;
            r_frame_error <= w_error;
            if (w_valid) r_scan_code <= r_shift;
        end
    end

    assign scan_code   = r_scan_code;
    assign scan_valid  = r_scan_valid;
    assign frame_error = r_frame_error;

endmodule

`default_nettype wire

// File: rtl/ps2_space_key.sv
// ============================================================================
// Module      : ps2_space_key
// Description : Make/break/extended decode of PS/2 scan codes into a level
//               button_pressed signal for one key.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ps2_space_key
    import ps2_pkg::*;
#(
    parameter int         FILTER_LEN     = 8,
    parameter int         TIMEOUT_CYCLES = 5000,
    parameter logic [7:0] KEY_CODE       = CODE_SPACE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       button_pressed,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_error
);

    logic r_break, r_ext, r_button;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .scan_code   (scan_code),
        .scan_valid  (scan_valid),
        .frame_error (frame_error)
    );

    // A bad frame drops any pending prefix so a corrupted F0 cannot turn
    // the next make code into a release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_break  <= 1'b0;
            r_ext    <= 1'b0;
            r_button <= 1'b0;
        end else if (frame_error) begin
            r_break <= 1'b0;
            r_ext   <= 1'b0;
        end else if (scan_valid) begin
            if (scan_code == CODE_BREAK) begin
                r_break <= 1'b1;
            end else if (scan_code == CODE_EXT) begin
                r_ext <= 1'b1;
            end else begin
                if ((scan_code == KEY_CODE) && !r_ext) r_button <= ~r_break;
                r_break <= 1'b0;
                r_ext   <= 1'b0;
            end
        end
    end

    assign button_pressed = r_button;

endmodule

`default_nettype wire

// File: tb/tb_ps2_space_key.sv
// ============================================================================
// Module      : tb_ps2_space_key
// Description : Randomised scoreboard bench for ps2_space_key.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ps2_space_key;

    localparam int HALF = 30;
    localparam int GAP  = 80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       button_pressed, scan_valid, frame_error;
    logic [7:0] scan_code;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         btn;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] m_prefix[$];
    bit         m_btn = 1'b0;
    logic [7:0] m_last = 8'h00;
    int         checks = 0;
    int         failures = 0;

    ps2_space_key #(
        .FILTER_LEN     (8),
        .TIMEOUT_CYCLES (5000),
        .KEY_CODE       (8'h29)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ps2_clk        (ps2_clk),
        .ps2_data       (ps2_data),
        .button_pressed (button_pressed),
        .scan_code      (scan_code),
        .scan_valid     (scan_valid),
        .frame_error    (frame_error)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit has_prefix(input logic [7:0] c);
        foreach (m_prefix[i]) if (m_prefix[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: prefix bytes accumulate until a non-prefix code consumes them.
    task automatic model_frame(input logic [7:0] code, input bit good);
        exp_t e;
        if (!good) begin
            m_prefix.delete();
            e.is_err = 1'b1;
        end else begin
            e.is_err = 1'b0;
            m_last   = code;
            if (code == 8'hF0 || code == 8'hE0) begin
                m_prefix.push_back(code);
            end else begin
                if (code == 8'h29 && !has_prefix(8'hE0)) m_btn = !has_prefix(8'hF0);
                m_prefix.delete();
            end
        end
        e.code = m_last;
        e.btn  = m_btn;
        exp_q.push_back(e);
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n, input bit glitch);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            if (glitch && i == 3) begin
                wait_cyc(10); ps2_clk = 1'b0; wait_cyc(3); ps2_clk = 1'b1; wait_cyc(HALF - 13);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b0;
            if (glitch && i == 5) begin
                wait_cyc(10); ps2_clk = 1'b1; wait_cyc(3); ps2_clk = 1'b0; wait_cyc(HALF - 13);
            end else begin
                wait_cyc(HALF);
            end
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                              input bit glitch);
        logic par;
        par = ~(^code) ^ bad_par;
        model_frame(code, !bad_par && !bad_stop);
        send_bits({~bad_stop, par, code, 1'b0}, 11, glitch);
        wait_cyc(GAP);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        wait_cyc(3);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_model();
        m_prefix.delete();
        m_btn  = 1'b0;
        m_last = 8'h00;
    endtask

    // Monitor: pops one expectation per DUT event, checks button one cycle later.
    bit pend = 1'b0;
    bit pend_btn = 1'b0;
    bit mon_btn = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            pend    = 1'b0;
            mon_btn = 1'b0;
        end else begin
            if (pend) begin
                chk("button_after_event", 32'(button_pressed), 32'(pend_btn));
                mon_btn = pend_btn;
                pend    = 1'b0;
            end else if (button_pressed !== mon_btn) begin
                chk("button_stable", 32'(button_pressed), 32'(mon_btn));
            end
            if (scan_valid || frame_error) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 32'({scan_valid, frame_error}), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("scan_valid", 32'(scan_valid), 32'(!e.is_err));
                    chk("frame_error", 32'(frame_error), 32'(e.is_err));
                    chk("scan_code", 32'(scan_code), 32'(e.code));
                    pend     = 1'b1;
                    pend_btn = e.btn;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [7:0] code;
        wait_cyc(5);
        chk("reset_button", 32'(button_pressed), 32'd0);
        chk("reset_scan_code", 32'(scan_code), 32'd0);
        chk("reset_scan_valid", 32'(scan_valid), 32'd0);
        chk("reset_frame_error", 32'(frame_error), 32'd0);
        rst_n = 1'b1;
        wait_cyc(20);

        // Press, release.
        send_frame(8'h29, 0, 0, 0);
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h29, 0, 0, 0);
        // Press, then corrupted repeat keeps state.
        send_frame(8'h29, 0, 0, 0);
        send_frame(8'h29, 1, 0, 0);
        send_frame(8'h29, 0, 0, 0);
        // Release, extended make ignored, plain make presses.
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h29, 0, 0, 0);
        send_frame(8'hE0, 0, 0, 0);
        send_frame(8'h29, 0, 0, 0);
        send_frame(8'h29, 0, 0, 0);
        // Release, corrupted F0 must not cause the next make to release.
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h29, 0, 0, 0);
        send_frame(8'hF0, 1, 0, 0);
        send_frame(8'h29, 0, 0, 0);
        // Bad stop bit.
        send_frame(8'h5A, 0, 1, 0);
        // Start bit of 1: single edge produces one error.
        model_frame(8'h00, 0);
        send_bits(11'h001, 1, 0);
        wait_cyc(GAP);
        drain(2000);

        // Timeout after five data bits.
        send_frame(8'hF0, 0, 0, 0);
        model_frame(8'h00, 0);
        send_bits({1'b1, 1'b1, 8'h29, 1'b0}, 6, 0);
        n = 0;
        while (!frame_error && n < 5400) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_window", 32'(n >= 4970 && n <= 4995), 32'd1);
        wait_cyc(20);
        send_frame(8'h29, 0, 0, 0);

        // Glitched clock.
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h29, 0, 0, 0);
        send_frame(8'h29, 0, 0, 1);
        drain(2000);

        for (int i = 0; i < 30; i++) begin
            n = int'($urandom_range(0, 9));
            if (n < 4)      code = 8'h29;
            else if (n < 6) code = 8'hF0;
            else if (n < 7) code = 8'hE0;
            else            code = 8'($urandom);
            send_frame(code, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0, 0);
        end
        drain(2000);

        // Reset mid-frame while pressed.
        send_frame(8'h29, 0, 0, 0);
        send_frame(8'h29, 0, 0, 0);
        drain(2000);
        wait_cyc(5);
        chk("button_before_reset", 32'(button_pressed), 32'd1);
        send_bits({1'b1, 1'b1, 8'h29, 1'b0}, 5, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_button", 32'(button_pressed), 32'd0);
        chk("midreset_scan_code", 32'(scan_code), 32'd0);
        chk("midreset_scan_valid", 32'(scan_valid), 32'd0);
        chk("midreset_frame_error", 32'(frame_error), 32'd0);
        reset_model();
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(20);
        send_frame(8'h29, 0, 0, 0);
        drain(2000);
        chk("final_button", 32'(button_pressed), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
